multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32 core subset: addi, lw, sw, beq, bge.
- Sequences the shared datapath through fetch, decode, execute, memory and writeback: single memory port, single ALU, IMMGEN driven from the IR.
- Drives all mux selects and write enables.
- Handshakes with the unified memory via MEM_READY.

---
 rtl/cpu_ctrl_pkg.sv | 54 +++++
 rtl/ctrl_outdec.sv | 82 ++++++++
 rtl/multicycle_ctrl.sv | 94 +++++++++
 tb/tb_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32 control path:
// state encodings, opcode/funct3 values, ALU select codes and the decode helper.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_I = 4'd3,
        S_ALU_WB = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_LD = 4'd6,
        S_LD_WB  = 4'd7,
        S_MEM_ST = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BGE  = 3'b101;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    // Anything outside the supported subset lands in TRAP.
    function automatic state_t decode_next(input logic [6:0] opcode, input logic [2:0] funct3);
        state_t nxt;
        nxt = S_TRAP;
        if (opcode == OP_IMM && funct3 == F3_ADDI)
            nxt = S_EXEC_I;
        else if ((opcode == OP_LOAD && funct3 == F3_LW) || (opcode == OP_STORE && funct3 == F3_SW))
            nxt = S_ADDR;
        else if (opcode == OP_BRANCH && (funct3 == F3_BEQ || funct3 == F3_BGE))
            nxt = S_BRANCH;
        return nxt;
    endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational control-output decoder: Moore outputs from the state, plus the
// MEM_READY-qualified fetch writes and the ZERO/LT-qualified branch PC write.
module ctrl_outdec
    import cpu_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic        mem_ready,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        lt,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        reg_we,
    output logic        memtoreg,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        illegal
);

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        reg_we    = 1'b0;
        memtoreg  = 1'b0;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_ADD;
        illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
            end
            S_EXEC_I, S_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_ALU_WB: reg_we = 1'b1;
            S_MEM_LD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            S_LD_WB: begin
                reg_we   = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEM_ST: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                // Taken decision comes straight from the ALU flags this cycle.
                if (funct3 == F3_BEQ)
                    pc_we = zero;
                else if (funct3 == F3_BGE)
                    pc_we = ~lt;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32 subset core (addi, lw, sw, beq, bge).
// Optional retired-instruction counter: define MULTICYCLE_PERF_CNT_EN.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [6:0]       OPCODE,
    input  logic [2:0]       FUNCT3,
    input  logic             ZERO,
    input  logic             LT,
    input  logic             MEM_READY,
    output logic             MEM_RD,
    output logic             MEM_WR,
    output logic             IORD,
    output logic             IR_WE,
    output logic             PC_WE,
    output logic             PC_SRC,
    output logic             REG_WE,
    output logic             MEMTOREG,
    output logic [1:0]       ALU_SRC_A,
    output logic [1:0]       ALU_SRC_B,
    output logic [1:0]       ALU_OP,
    output logic             ILLEGAL,
    output logic [3:0]       STATE,
    output logic [CNT_W-1:0] RETIRED
);

    state_t state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  if (MEM_READY) state <= S_DECODE;
                S_DECODE: state <= decode_next(OPCODE, FUNCT3);
                S_EXEC_I: state <= S_ALU_WB;
                S_ADDR:   state <= (OPCODE == OP_LOAD) ? S_MEM_LD : S_MEM_ST;
                S_MEM_LD: if (MEM_READY) state <= S_LD_WB;
                S_MEM_ST: if (MEM_READY) state <= S_FETCH;
                S_ALU_WB, S_LD_WB, S_BRANCH: state <= S_FETCH;
                S_TRAP:   state <= S_TRAP;
                default:  state <= S_TRAP;
            endcase
        end
    end

    assign STATE = state;

    ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (MEM_READY),
        .funct3    (FUNCT3),
        .zero      (ZERO),
        .lt        (LT),
        .mem_rd    (MEM_RD),
        .mem_wr    (MEM_WR),
        .iord      (IORD),
        .ir_we     (IR_WE),
        .pc_we     (PC_WE),
        .pc_src    (PC_SRC),
        .reg_we    (REG_WE),
        .memtoreg  (MEMTOREG),
        .alu_src_a (ALU_SRC_A),
        .alu_src_b (ALU_SRC_B),
        .alu_op    (ALU_OP),
        .illegal   (ILLEGAL)
    );

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [CNT_W-1:0] retired;
    logic             retire;

    // An instruction retires on the edge that takes its last state back to FETCH.
    assign retire = (state == S_ALU_WB) || (state == S_LD_WB) || (state == S_BRANCH) ||
                    (state == S_MEM_ST && MEM_READY);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            retired <= '0;
        else if (retire)
            retired <= retired + CNT_W'(1);
    end

    assign RETIRED = retired;
`else
    assign RETIRED = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: instruction-level timing
// model generates the expected per-cycle state and control word.
module tb_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNCT3;
    logic        ZERO, LT, MEM_READY;
    logic        MEM_RD, MEM_WR, IORD, IR_WE, PC_WE, PC_SRC, REG_WE, MEMTOREG, ILLEGAL;
    logic [1:0]  ALU_SRC_A, ALU_SRC_B, ALU_OP;
    logic [3:0]  STATE;
    logic [31:0] RETIRED;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_ret = 0;
    logic [14:0] ctl_obs;

    always #5 CLK = ~CLK;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .ZERO(ZERO), .LT(LT),
        .MEM_READY(MEM_READY), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .IORD(IORD), .IR_WE(IR_WE),
        .PC_WE(PC_WE), .PC_SRC(PC_SRC), .REG_WE(REG_WE), .MEMTOREG(MEMTOREG),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP), .ILLEGAL(ILLEGAL),
        .STATE(STATE), .RETIRED(RETIRED)
    );

    assign ctl_obs = {MEM_RD, MEM_WR, IORD, IR_WE, PC_WE, PC_SRC, REG_WE, MEMTOREG,
                      ALU_SRC_A, ALU_SRC_B, ALU_OP, ILLEGAL};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [14:0] w(input bit rd, input bit wr, input bit io, input bit ir,
                                      input bit pw, input bit ps, input bit rw, input bit mr,
                                      input bit [1:0] a, input bit [1:0] b, input bit [1:0] op,
                                      input bit il);
        return {rd, wr, io, ir, pw, ps, rw, mr, a, b, op, il};
    endfunction

    function automatic bit legal(input logic [6:0] op, input logic [2:0] f3);
        return (op == 7'b0010011 && f3 == 3'b000) || (op == 7'b0000011 && f3 == 3'b010) ||
               (op == 7'b0100011 && f3 == 3'b010) ||
               (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b101));
    endfunction

    task automatic note_retire();
`ifdef MULTICYCLE_PERF_CNT_EN
        exp_ret = exp_ret + 1;
`endif
    endtask

    // One clock cycle: entered at posedge+1, drive inputs, check at +4, leave at next posedge+1.
    task automatic cyc(input logic rdy, input logic z, input logic l,
                       input logic [3:0] st, input logic [14:0] ctl);
        MEM_READY = rdy;
        ZERO = z;
        LT = l;
        #3;
        check("state", 32'(STATE), 32'(st));
        check("ctl", 32'(ctl_obs), 32'(ctl));
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        check("rst_state", 32'(STATE), 32'd0);
        check("rst_ctl", 32'(ctl_obs), 32'd0);
        check("rst_memwr", 32'(MEM_WR), 32'd0);
        check("rst_retired", RETIRED, 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        exp_ret = 0;
        cyc(1'($urandom), 1'($urandom), 1'($urandom), 4'd0, 15'd0);
    endtask

    task automatic fetch_decode(input int wf, input logic [6:0] op, input logic [2:0] f3);
        check("retired", RETIRED, exp_ret);
        OPCODE = 7'($urandom);
        FUNCT3 = 3'($urandom);
        for (int i = 0; i <= wf; i++) begin
            cyc(i == wf, 1'($urandom), 1'($urandom), 4'd1,
                w(1, 0, 0, i == wf, i == wf, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0));
        end
        OPCODE = op;
        FUNCT3 = f3;
        cyc(1'($urandom), 1'($urandom), 1'($urandom), 4'd2,
            w(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0));
    endtask

    // kind: 0 addi, 1 lw, 2 sw, 3 beq, 4 bge
    task automatic run_instr(input int kind, input int wf, input int wm, input logic z, input logic l);
        logic [6:0] op;
        logic [2:0] f3;
        case (kind)
            0: begin op = 7'b0010011; f3 = 3'b000; end
            1: begin op = 7'b0000011; f3 = 3'b010; end
            2: begin op = 7'b0100011; f3 = 3'b010; end
            3: begin op = 7'b1100011; f3 = 3'b000; end
            default: begin op = 7'b1100011; f3 = 3'b101; end
        endcase
        fetch_decode(wf, op, f3);
        case (kind)
            0: begin
                cyc(1'($urandom), 1'($urandom), 1'($urandom), 4'd3,
                    w(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 0));
                cyc(1'($urandom), 1'($urandom), 1'($urandom), 4'd4,
                    w(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
            end
            1, 2: begin
                cyc(1'($urandom), 1'($urandom), 1'($urandom), 4'd5,
                    w(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 0));
                for (int i = 0; i <= wm; i++) begin
                    if (kind == 1)
                        cyc(i == wm, 1'($urandom), 1'($urandom), 4'd6,
                            w(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
                    else
                        cyc(i == wm, 1'($urandom), 1'($urandom), 4'd8,
                            w(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
                end
                if (kind == 1)
                    cyc(1'($urandom), 1'($urandom), 1'($urandom), 4'd7,
                        w(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0));
            end
            default: begin
                cyc(1'($urandom), z, l, 4'd9,
                    w(0, 0, 0, 0, (kind == 3) ? z : ~l, 1, 0, 0, 2'b10, 2'b00, 2'b01, 0));
            end
        endcase
        note_retire();
    endtask

    task automatic run_illegal(input logic [6:0] op, input logic [2:0] f3);
        fetch_decode($urandom_range(0, 2), op, f3);
        for (int i = 0; i < 20; i++) begin
            OPCODE = 7'($urandom);
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 4'd15,
                w(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1));
        end
        do_reset();
    endtask

    task automatic mid_store_reset();
        fetch_decode(0, 7'b0100011, 3'b010);
        cyc(1'($urandom), 1'($urandom), 1'($urandom), 4'd5,
            w(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 0));
        MEM_READY = 1'b0;
        #3;
        check("st_state", 32'(STATE), 32'd8);
        check("st_memwr", 32'(MEM_WR), 32'd1);
        do_reset();
    endtask

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        RST_N = 1'b0;
        OPCODE = '0;
        FUNCT3 = '0;
        ZERO = 1'b0;
        LT = 1'b0;
        MEM_READY = 1'b1;
        @(posedge CLK);
        #1;
        do_reset();

        run_instr(0, 0, 0, 1'b0, 1'b0);       // addi x1,x0,5 with zero-wait memory
        run_instr(1, 0, 3, 1'b0, 1'b0);       // lw x2,4(x1) with 3 wait states
        run_instr(3, 0, 0, 1'b1, 1'b0);       // beq taken
        run_instr(3, 0, 0, 1'b0, 1'b0);       // beq not taken
        run_instr(4, 0, 0, 1'b0, 1'b1);       // bge with LT -> not taken
        run_instr(4, 0, 0, 1'b0, 1'b0);       // bge taken
        run_instr(2, 1, 2, 1'b0, 1'b0);
        run_illegal(7'b0110111, 3'b000);
        mid_store_reset();

        for (int n = 0; n < 60; n++) begin
            run_instr($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom));
            if (n % 20 == 19) begin
                do begin
                    op = 7'($urandom);
                    f3 = 3'($urandom);
                end while (legal(op, f3));
                run_illegal(op, f3);
            end
        end
        check("retired_end", RETIRED, exp_ret);
        check("state_end", 32'(STATE), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
